shared_reg_arbiter: RTL
=======================

# shared_reg_arbiter

Round-robin arbiter and write sequencer for one shared WIDTH-bit D-flip-flop storage register. It serves NREQ requesters. The block decides which requester owns the register and sequences a grant/capture/acknowledge handshake. It drives the register's load and the registered output value. It sits between several producer blocks and the single positive-edge-triggered storage register they share.

## Interface
Parameters:
- WIDTH, 8, bit width of the shared register and of each requester's write data
- NREQ, 4, number of requesters (2..8); index width IW = $clog2(NREQ)

Ports:
- clk  input  1  single clock; all state updates on posedge clk
- rst_n  input  1  reset, synchronous and active-low; sampled on posedge clk
- req  input  NREQ  level request per requester; held high with stable data until ack
- wdata  input  NREQ*WIDTH  flattened write data; requester i uses bits [i*WIDTH +: WIDTH]
- gnt  output  NREQ  one-hot grant; high for exactly the capture cycle
- ack  output  NREQ  one-hot, one-cycle write-complete pulse
- q  output  WIDTH  current shared register contents
- owner  output  IW  index of last requester written (valid after first write)
- busy  output  1  high in GRANT and ACK states

## Operation
- FSM states: IDLE, GRANT, ACK.
- IDLE:
  - If req==0, stay in IDLE.
  - Otherwise pick winner w by round-robin, go to GRANT, and latch w.
- GRANT:
  - gnt[w]=1.
  - At the clock edge ending this cycle, q <= wdata[w], owner <= w, and the pointer becomes w.
  - Always go to ACK. A req[w] drop during GRANT does not abort the write.
- ACK:
  - ack[w]=1.
  - Mask req[w] and arbitrate among the remaining requests.
  - If any remain, go directly to GRANT with the new winner. Otherwise go to IDLE.
- Round-robin order: search starts at pointer+1 and wraps modulo NREQ. The first set request wins. The last-served requester has the lowest priority.
- Requester protocol:
  - Deassert req on the edge where ack is sampled high.
  - A req still high in the cycle after ack is a new request.
- q changes only on a GRANT-cycle edge; it holds its value otherwise.
- gnt and ack are never both nonzero. Each is zero or one-hot.
- Reset (rst_n low at a posedge):
  - State = IDLE; gnt = 0; ack = 0; q = 0; owner = 0.
  - Pointer = NREQ-1, so requester 0 has highest priority after reset.
  - busy = 0.
  - Reset overrides all transitions. A write in GRANT at that edge is discarded and no ack is issued.

## Timing
- Single request from IDLE, req rising before edge E0:
  - GRANT in cycle E0..E1.
  - New q visible after E1.
  - ACK in cycle E1..E2.
  - Back in IDLE after E2.
- Latency req to ack: 2 cycles. Latency req to q updated: 2 edges.
- Back-to-back throughput: one write per 2 cycles while other requests are pending (ACK→GRANT).
- gnt, ack and busy are registered state decodes, with no combinational path from req to outputs.
- Simultaneous requests are resolved in the single arbitration cycle. Requests arriving during GRANT are considered at the next ACK cycle.

## Test plan
- Reset: drive rst_n=0 for 2 cycles with req=4'b1111 -> q=0, gnt=0, ack=0, busy=0. After release, first gnt=4'b0001.
- Single write: req[2]=1, wdata[2]=8'hA5 from IDLE -> gnt=4'b0100 for 1 cycle, then ack=4'b0100 and q=8'hA5, owner=2. Deassert req[2] -> IDLE.
- Fairness: hold req=4'b1111 and each requester drops req on its ack, then re-raises it one cycle later -> grant order 0,1,2,3,0,… with writes every 2 cycles, and q follows each wdata.
- Wrap-around: pointer=3, req=4'b1001 -> requester 0 granted before 3.
- Reset mid-operation: assert rst_n=0 in the GRANT cycle with wdata=8'h3C -> q=0, no ack pulse, state IDLE.
- Protocol edge: req[1] drops during its GRANT cycle -> write still completes (q=wdata[1]) and ack[1] pulses. A req[1] held high after ack -> treated as a new request after other pending requesters are served.

Source files
------------

// File: rtl/shared_reg_arbiter.sv
// Round-robin owner arbitration and grant/capture/ack sequencing for one
// shared WIDTH-bit storage register written by NREQ requesters.
module shared_reg_arbiter #(
  parameter  int WIDTH = 8,
  parameter  int NREQ  = 4,
  localparam int IW    = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] wdata,
  output logic [NREQ-1:0]       gnt,
  output logic [NREQ-1:0]       ack,
  output logic [WIDTH-1:0]      q,
  output logic [IW-1:0]         owner,
  output logic                  busy
);

  typedef enum logic [1:0] {IDLE, GRANT, ACK} state_t;

  state_t                       state, state_d;
  logic   [IW-1:0]              w, w_d, ptr, pick;
  logic   [NREQ-1:0]            w_oh, cand;
  logic   [NREQ-1:0][WIDTH-1:0] wd;
  logic                         found;

  assign wd = wdata;

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_oh
      assign w_oh[gi] = (w == IW'(gi));
    end
  endgenerate

  // In ACK the requester just served is masked so it cannot win twice in a row
  assign cand = (state == ACK) ? (req & ~w_oh) : req;

  always_comb begin
    int idx;
    found = 1'b0;
    pick  = ptr;
    idx   = 0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NREQ) idx -= NREQ;
      if (!found && cand[idx]) begin
        found = 1'b1;
        pick  = IW'(idx);
      end
    end
  end

  always_comb begin
    state_d = state;
    w_d     = w;
    case (state)
      IDLE: if (found) begin
        state_d = GRANT;
        w_d     = pick;
      end
      GRANT: state_d = ACK;
      ACK: begin
        if (found) begin
          state_d = GRANT;
          w_d     = pick;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      w     <= '0;
      ptr   <= IW'(NREQ - 1);
      q     <= '0;
      owner <= '0;
    end else begin
      state <= state_d;
      w     <= w_d;
      if (state == GRANT) begin
        q     <= wd[w];
        owner <= w;
        ptr   <= w;
      end
    end
  end

  assign gnt  = (state == GRANT) ? w_oh : '0;
  assign ack  = (state == ACK)   ? w_oh : '0;
  assign busy = (state != IDLE);

endmodule
